out_display: RTL and testbench



---
 rtl/out_display_pkg.sv | 52 +++++
 rtl/out_display_bin_to_bcd.sv | 77 +++++++
 rtl/out_display.sv | 204 ++++++++++++++++++++
 tb/tb_out_display.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/out_display_pkg.sv
// Shared definitions for the output display driver: segment glyphs,
// controller state encoding and small arithmetic helpers.
package out_display_pkg;

  // Number of double-dabble iterations for an 8-bit magnitude
  localparam int CONV_STEPS = 8;

  // Segment patterns {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Capture/convert controller states
  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Map one BCD digit to its segment pattern; non-decimal codes go dark
  function automatic logic [6:0] bcd_glyph(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Absolute value of the byte; 0x80 maps to 128 since the result is unsigned
  function automatic logic [7:0] to_magnitude(input logic [7:0] value, input logic negative);
    return negative ? (~value + 8'd1) : value;
  endfunction

endpackage

// File: rtl/out_display_bin_to_bcd.sv
// Iterative 8-bit binary to 3-digit BCD converter (double dabble).
// One iteration per clock; o_done pulses during the last iteration and the
// digit outputs carry that iteration's result so the caller can commit on
// the same edge the converter goes idle.
module out_display_bin_to_bcd
  import out_display_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_mag,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_hundreds,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  // Working register: {hundreds, tens, ones, binary}
  logic [19:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  logic [19:0] adj;
  logic [19:0] shifted;
  logic        last_step;

  // Binary part passes through untouched; each BCD nibble gets +3 when >= 5
  assign adj[7:0] = sr_q[7:0];

  for (genvar gi = 0; gi < 3; gi++) begin : g_adjust
    localparam int LSB = 8 + 4 * gi;
    assign adj[LSB +: 4] = (sr_q[LSB +: 4] >= 4'd5) ? (sr_q[LSB +: 4] + 4'd3)
                                                     : sr_q[LSB +: 4];
  end

  assign shifted   = adj << 1;
  assign last_step = (cnt_q == 3'(CONV_STEPS - 1));

  // Load on start, otherwise iterate while busy and stop after the last step
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (i_start) begin
      sr_d   = {12'd0, i_mag};
      cnt_d  = 3'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sr_d  = shifted;
      cnt_d = cnt_q + 3'd1;
      if (last_step) begin
        busy_d = 1'b0;
      end
    end
  end

  // Converter state registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = busy_q && last_step;
  assign o_hundreds = shifted[19:16];
  assign o_tens     = shifted[15:12];
  assign o_ones     = shifted[11:8];

endmodule

// File: rtl/out_display.sv
// Output display driver: captures the CPU output byte, converts it to
// decimal and scans a 4-digit multiplexed 7-segment display
// (digit 0 = ones ... digit 3 = sign) with leading-zero blanking.
module out_display
  import out_display_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_value,
  input  logic       i_signed,
  output logic [6:0] o_seg,
  output logic [3:0] o_an,
  output logic       o_busy
);

  localparam int              PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  // Controller
  state_t      state_q, state_d;
  logic        start;
  logic        start_req;
  logic        pair_changed;

  // Capture of the value being shown and the post-reset "must convert" flag
  logic [7:0]  cap_value_q, cap_value_d;
  logic        cap_signed_q, cap_signed_d;
  logic        invalid_q, invalid_d;
  logic        neg_q, neg_d;

  // Magnitude of the live input
  logic        mag_neg;
  logic [7:0]  mag;

  // Converter handshake
  logic        conv_busy;
  logic        conv_done;
  logic [3:0]  conv_hundreds;
  logic [3:0]  conv_tens;
  logic [3:0]  conv_ones;

  // Display registers
  logic [3:0]  disp_h_q, disp_h_d;
  logic [3:0]  disp_t_q, disp_t_d;
  logic [3:0]  disp_o_q, disp_o_d;
  logic        disp_neg_q, disp_neg_d;

  // Scan and segment drive
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]  idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        h_blank;
  logic        t_blank;

  assign pair_changed = {i_signed, i_value} != {cap_signed_q, cap_value_q};
  assign start_req    = pair_changed || invalid_q;
  assign mag_neg      = i_signed && i_value[7];
  assign mag          = to_magnitude(i_value, mag_neg);

  out_display_bin_to_bcd u_bin_to_bcd (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (start),
    .i_mag      (mag),
    .o_busy     (conv_busy),
    .o_done     (conv_done),
    .o_hundreds (conv_hundreds),
    .o_tens     (conv_tens),
    .o_ones     (conv_ones)
  );

  // Controller state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller next state; a converter that stops without done also returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = CONV;
        end
      end
      CONV: begin
        if (conv_done || !conv_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller outputs: inputs are only sampled while IDLE
  always_comb begin
    start  = 1'b0;
    o_busy = 1'b0;
    case (state_q)
      IDLE:    start  = start_req;
      CONV:    o_busy = 1'b1;
      default: begin
        start  = 1'b0;
        o_busy = 1'b0;
      end
    endcase
  end

  // Capture the input pair and its sign when a conversion starts
  always_comb begin
    cap_value_d  = cap_value_q;
    cap_signed_d = cap_signed_q;
    invalid_d    = invalid_q;
    neg_d        = neg_q;
    if (start) begin
      cap_value_d  = i_value;
      cap_signed_d = i_signed;
      invalid_d    = 1'b0;
      neg_d        = mag_neg;
    end
  end

  // Commit converted digits and the captured sign together
  always_comb begin
    disp_h_d   = disp_h_q;
    disp_t_d   = disp_t_q;
    disp_o_d   = disp_o_q;
    disp_neg_d = disp_neg_q;
    if (conv_done) begin
      disp_h_d   = conv_hundreds;
      disp_t_d   = conv_tens;
      disp_o_d   = conv_ones;
      disp_neg_d = neg_q;
    end
  end

  // Prescaler and digit index; the index steps on each prescaler wrap
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  assign h_blank = (disp_h_q == 4'd0);
  assign t_blank = h_blank && (disp_t_q == 4'd0);

  // Glyph and anode for the current digit, from the registered display state
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = ~(4'b0001 << idx_q);
    case (idx_q)
      2'd0:    seg_d = bcd_glyph(disp_o_q);
      2'd1:    seg_d = t_blank ? SEG_BLANK : bcd_glyph(disp_t_q);
      2'd2:    seg_d = h_blank ? SEG_BLANK : bcd_glyph(disp_h_q);
      2'd3:    seg_d = disp_neg_q ? SEG_MINUS : SEG_BLANK;
      default: seg_d = SEG_BLANK;
    endcase
  end

  // Capture, display and scan registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cap_value_q  <= '0;
      cap_signed_q <= 1'b0;
      invalid_q    <= 1'b1;
      neg_q        <= 1'b0;
      disp_h_q     <= '0;
      disp_t_q     <= '0;
      disp_o_q     <= '0;
      disp_neg_q   <= 1'b0;
      pre_q        <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= 4'b1111;
    end else begin
      cap_value_q  <= cap_value_d;
      cap_signed_q <= cap_signed_d;
      invalid_q    <= invalid_d;
      neg_q        <= neg_d;
      disp_h_q     <= disp_h_d;
      disp_t_q     <= disp_t_d;
      disp_o_q     <= disp_o_d;
      disp_neg_q   <= disp_neg_d;
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign o_seg = seg_q;
  assign o_an  = an_q;

endmodule

// File: tb/tb_out_display.sv
// Self-checking bench for out_display with a fast scan rate.
module tb_out_display;

  localparam int SCAN_DIV = 4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [7:0] i_value = 8'd0;
  logic       i_signed = 1'b0;
  logic [6:0] o_seg;
  logic [3:0] o_an;
  logic       o_busy;

  int tests  = 0;
  int failed = 0;

  out_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_value  (i_value),
    .i_signed (i_signed),
    .o_seg    (o_seg),
    .o_an     (o_an),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] g;
    case (d)
      0: g = 7'h3F;  1: g = 7'h06;  2: g = 7'h5B;  3: g = 7'h4F;  4: g = 7'h66;
      5: g = 7'h6D;  6: g = 7'h7D;  7: g = 7'h07;  8: g = 7'h7F;  9: g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Expected four glyphs {sign, hundreds, tens, ones} from plain decimal arithmetic
  function automatic logic [27:0] ref_digits(input logic [7:0] v, input logic s);
    int n, h, t, o;
    logic neg;
    logic [27:0] r;
    neg = s && v[7];
    n   = neg ? 256 - int'(v) : int'(v);
    h   = n / 100;
    t   = (n / 10) % 10;
    o   = n % 10;
    r[6:0]   = glyph(o);
    r[13:7]  = (h == 0 && t == 0) ? 7'h00 : glyph(t);
    r[20:14] = (h == 0) ? 7'h00 : glyph(h);
    r[27:21] = neg ? 7'h40 : 7'h00;
    return r;
  endfunction

  function automatic int an_pos(input logic [3:0] an);
    int p;
    case (an)
      4'b1110: p = 0;
      4'b1101: p = 1;
      4'b1011: p = 2;
      4'b0111: p = 3;
      default: p = -1;
    endcase
    return p;
  endfunction

  // Wait (bounded) for busy, then count how many sampled cycles it stays high
  task automatic measure_busy(output int len);
    int w;
    w = 0;
    len = 0;
    while (o_busy !== 1'b1 && w < 20) begin
      @(negedge i_clk);
      w++;
    end
    while (o_busy === 1'b1 && len < 20) begin
      len++;
      @(negedge i_clk);
    end
  endtask

  // Watch a few full scans: check anode rotation/period and collect each digit
  task automatic capture_check(input logic [7:0] v, input logic s, input string tag);
    logic [27:0] seen;
    logic [27:0] exp;
    logic [3:0]  prev;
    int          run_len;
    int          p;
    bit          first_run;
    seen      = 'x;
    exp       = ref_digits(v, s);
    prev      = 4'b1111;
    run_len   = 0;
    first_run = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge i_clk);
      p = an_pos(o_an);
      check_eq({tag, "_an_onehot"}, 32'(p >= 0), 32'd1);
      if (p >= 0) seen[p*7 +: 7] = o_seg;
      if (i == 0) begin
        prev    = o_an;
        run_len = 1;
      end else if (o_an !== prev) begin
        check_eq({tag, "_an_rot"}, 32'(o_an), 32'({prev[2:0], prev[3]}));
        if (!first_run) check_eq({tag, "_an_period"}, run_len, SCAN_DIV);
        first_run = 1'b0;
        prev      = o_an;
        run_len   = 1;
      end else begin
        run_len++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("%s_dig%0d", tag, k), 32'(seen[k*7 +: 7]), 32'(exp[k*7 +: 7]));
    end
    $display("[TB] %s value=%0d signed=%0d seg sign/h/t/o = %02h %02h %02h %02h",
             tag, v, s, seen[27:21], seen[20:14], seen[13:7], seen[6:0]);
  endtask

  task automatic apply(input logic [7:0] v, input logic s, input string tag);
    int len;
    @(negedge i_clk);
    i_value  = v;
    i_signed = s;
    measure_busy(len);
    check_eq({tag, "_busy_len"}, len, 8);
    capture_check(v, s, tag);
  endtask

  // Change the input three cycles into a conversion; it must be picked up afterwards
  task automatic mid_change();
    logic [27:0] exp10;
    int p;
    exp10 = ref_digits(8'd10, 1'b0);
    @(negedge i_clk);
    i_value  = 8'd10;
    i_signed = 1'b0;
    @(negedge i_clk);
    check_eq("mid_busy_k0", 32'(o_busy), 32'd1);
    repeat (3) @(negedge i_clk);
    i_value = 8'd20;
    for (int j = 4; j <= 17; j++) begin
      @(negedge i_clk);
      check_eq($sformatf("mid_busy_k%0d", j), 32'(o_busy), (j == 8 || j == 17) ? 32'd0 : 32'd1);
      if (j >= 9) begin
        p = an_pos(o_an);
        if (p >= 0) check_eq($sformatf("mid_seg10_k%0d", j), 32'(o_seg), 32'(exp10[p*7 +: 7]));
      end
    end
    capture_check(8'd20, 1'b0, "mid20");
  endtask

  task automatic release_and_check(input logic [7:0] v, input logic s, input string tag);
    logic [27:0] zero_ref;
    int len;
    zero_ref = ref_digits(8'd0, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_eq({tag, "_first_an"}, 32'(o_an), 32'b1110);
    check_eq({tag, "_first_seg"}, 32'(o_seg), 32'(zero_ref[6:0]));
    check_eq({tag, "_first_busy"}, 32'(o_busy), 32'd1);
    measure_busy(len);
    check_eq({tag, "_busy_len"}, len, 8);
    capture_check(v, s, tag);
  endtask

  // Reset asserted four cycles into a conversion
  task automatic reset_mid();
    @(negedge i_clk);
    i_value  = 8'd200;
    i_signed = 1'b0;
    @(negedge i_clk);
    check_eq("rstmid_busy_k0", 32'(o_busy), 32'd1);
    repeat (4) @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    check_eq("rstmid_seg", 32'(o_seg), 32'h00);
    check_eq("rstmid_an", 32'(o_an), 32'hF);
    check_eq("rstmid_busy", 32'(o_busy), 32'd0);
    repeat (3) @(negedge i_clk);
    check_eq("rstmid_hold_an", 32'(o_an), 32'hF);
    check_eq("rstmid_hold_busy", 32'(o_busy), 32'd0);
    release_and_check(8'd200, 1'b0, "rstmid");
  endtask

  initial begin
    logic [7:0] rv, last_v;
    logic       rs, last_s;
    #12;
    check_eq("reset_seg", 32'(o_seg), 32'h00);
    check_eq("reset_an", 32'(o_an), 32'hF);
    check_eq("reset_busy", 32'(o_busy), 32'd0);
    release_and_check(8'd0, 1'b0, "zero");

    apply(8'd255, 1'b0, "u255");
    apply(8'h80, 1'b1, "s80");
    apply(8'h80, 1'b0, "u80");
    apply(8'd7, 1'b0, "u7");
    apply(8'd105, 1'b0, "u105");
    apply(8'hFF, 1'b1, "sFF");
    mid_change();
    reset_mid();

    last_v = 8'd200;
    last_s = 1'b0;
    for (int r = 0; r < 20; r++) begin
      rv = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if ({rs, rv} == {last_s, last_v}) rv = rv ^ 8'h01;
      apply(rv, rs, $sformatf("rnd%0d", r));
      last_v = rv;
      last_s = rs;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
